// File: rtl/crc_pkg.sv
// Shared CRC definitions: standard polynomials, stream FSM state encoding and
// a single-bit reference step for MSB-first CRC shifting.
package crc_pkg;

    localparam logic [23:0] CRC24A = 24'h864CFB;
    localparam logic [23:0] CRC24B = 24'h800063;
    localparam logic [15:0] CRC16  = 16'h1021;
    localparam logic [7:0]  CRC8   = 8'h9B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_APPEND = 2'd2,
        ST_DRAIN  = 2'd3
    } crc_state_e;

    // One serial step of a 24-bit CRC; the implicit x^24 term is the feedback.
    function automatic logic [23:0] crc_step(input logic [23:0] state,
                                             input logic        data,
                                             input logic [23:0] poly);
        logic [23:0] nxt;
        nxt = {state[22:0], 1'b0};
        if (data ^ state[23]) begin
            nxt = nxt ^ poly;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/crc_par_update.sv
// Combinational next-state network for a CRC absorbing DATA_W bits MSB-first,
// built as DATA_W chained serial steps that synthesis flattens into XOR trees.
module crc_par_update #(
    parameter int CRC_W  = 24,
    parameter int DATA_W = 8
) (
    input  logic [CRC_W-1:0]  crc_state,
    input  logic [DATA_W-1:0] data,
    input  logic [CRC_W-1:0]  poly,
    output logic [CRC_W-1:0]  crc_next
);

    logic [CRC_W-1:0] chain_s [DATA_W+1];

    assign chain_s[0] = crc_state;

    for (genvar i = 0; i < DATA_W; i++) begin : g_step
        logic fb_s;
        assign fb_s         = data[DATA_W-1-i] ^ chain_s[i][CRC_W-1];
        assign chain_s[i+1] = {chain_s[i][CRC_W-2:0], 1'b0} ^ ({CRC_W{fb_s}} & poly);
    end

    assign crc_next = chain_s[DATA_W];

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: passes data through a single output register,
// then either appends the CRC (GEN) or reports a zero-residue verdict (CHECK).
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 24,
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY_A = CRC24A,
    parameter logic [CRC_W-1:0] POLY_B = CRC24B,
    parameter logic [CRC_W-1:0] INIT   = {CRC_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              poly_sel,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_done,
    output logic              crc_ok
);

    localparam int NCHUNK = CRC_W / DATA_W;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

    crc_state_e        state_r, state_nx_s;
    logic              mode_r, poly_sel_r, busy_r;
    logic [CRC_W-1:0]  crc_r, crc_next_s, poly_s, crc_out_r;
    logic [K_W-1:0]    k_r;
    logic              out_valid_r, out_last_r, crc_done_r, crc_ok_r;
    logic [DATA_W-1:0] out_data_r, chunk_s;
    logic              out_free_s, in_ready_s, in_fire_s, chunk_load_s;
    logic              start_acc_s, frame_end_s;
    logic [DATA_W-1:0] chunk_arr_s [NCHUNK];

    assign poly_s     = poly_sel_r ? POLY_B : POLY_A;
    assign out_free_s = !out_valid_r || out_ready;
    assign in_fire_s  = in_valid && in_ready_s;

    crc_par_update #(.CRC_W(CRC_W), .DATA_W(DATA_W)) u_update (
        .crc_state (crc_r),
        .data      (in_data),
        .poly      (poly_s),
        .crc_next  (crc_next_s)
    );

    // CRC chunks leave most-significant first
    for (genvar j = 0; j < NCHUNK; j++) begin : g_chunk
        assign chunk_arr_s[j] = crc_r[CRC_W-1-j*DATA_W -: DATA_W];
    end
    assign chunk_s = chunk_arr_s[k_r];

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and per-state flow control
    always_comb begin
        state_nx_s   = state_r;
        in_ready_s   = 1'b0;
        chunk_load_s = 1'b0;
        start_acc_s  = 1'b0;
        frame_end_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    state_nx_s  = ST_DATA;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_DATA: begin
                in_ready_s = out_free_s;
                if (in_valid && out_free_s && in_last) begin
                    state_nx_s = mode_r ? ST_DRAIN : ST_APPEND;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_APPEND: begin
                chunk_load_s = out_free_s;
                if (out_free_s && (k_r == K_LAST)) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_APPEND;
                end
            end
            ST_DRAIN: begin
                if (out_valid_r && out_ready && out_last_r) begin
                    frame_end_s = 1'b1;
                    state_nx_s  = ST_IDLE;
                end else begin
                    state_nx_s  = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Frame context, running CRC, append counter and verdict registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r     <= 1'b0;
            poly_sel_r <= 1'b0;
            busy_r     <= 1'b0;
            crc_r      <= {CRC_W{1'b0}};
            k_r        <= {K_W{1'b0}};
            crc_out_r  <= {CRC_W{1'b0}};
            crc_done_r <= 1'b0;
            crc_ok_r   <= 1'b0;
        end else begin
            if (start_acc_s) begin
                mode_r     <= mode;
                poly_sel_r <= poly_sel;
                busy_r     <= 1'b1;
                crc_r      <= INIT;
                k_r        <= {K_W{1'b0}};
            end else begin
                if (in_fire_s) begin
                    crc_r <= crc_next_s;
                end
                if (chunk_load_s) begin
                    k_r <= k_r + K_W'(1);
                end
                if (frame_end_s) begin
                    busy_r <= 1'b0;
                end
            end
            crc_done_r <= in_fire_s && in_last;
            if (in_fire_s && in_last) begin
                crc_out_r <= crc_next_s;
                crc_ok_r  <= mode_r && (crc_next_s == {CRC_W{1'b0}});
            end
        end
    end

    // Single output register: holds while stalled, data beats take priority over CRC chunks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
        end else if (in_fire_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data;
            out_last_r  <= mode_r && in_last;
        end else if (chunk_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= chunk_s;
            out_last_r  <= (k_r == K_LAST);
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign busy      = busy_r;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign crc_out   = crc_out_r;
    assign crc_done  = crc_done_r;
    assign crc_ok    = crc_ok_r;

endmodule
